// File: rtl/des_round_sequencer.sv
// Iterative DES sequencer: IP/PC-1 on accept, one Feistel round per cycle through an external f, FP on exit.
// Optional macro DES_DECRYPT_EN: honours mode_i and adds the right-rotating decrypt key schedule.
module des_round_sequencer #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:64] data_i,
    input  logic [1:64] key_i,
    input  logic        mode_i,
    output logic [1:32] r_o,
    output logic [1:48] subkey_o,
    input  logic [1:32] f_i,
    output logic [4:0]  round_o,
    output logic        busy_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [1:64] data_o
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

    localparam logic [6:0] IP_TAB [1:64] = '{
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
        7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
        7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
        7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
        7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
    };

    localparam logic [6:0] FP_TAB [1:64] = '{
        7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
        7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
        7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
        7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
        7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
        7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
        7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
        7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
    };

    localparam logic [6:0] PC1_TAB [1:56] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    localparam logic [5:0] PC2_TAB [1:48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    function automatic logic [1:64] perm_ip(input logic [1:64] d);
        logic [1:64] o;
        for (int k = 1; k <= 64; k++) o[k] = d[IP_TAB[k]];
        return o;
    endfunction

    function automatic logic [1:64] perm_fp(input logic [1:64] d);
        logic [1:64] o;
        for (int k = 1; k <= 64; k++) o[k] = d[FP_TAB[k]];
        return o;
    endfunction

    function automatic logic [1:56] perm_pc1(input logic [1:64] d);
        logic [1:56] o;
        for (int k = 1; k <= 56; k++) o[k] = d[PC1_TAB[k]];
        return o;
    endfunction

    function automatic logic [1:48] perm_pc2(input logic [1:56] d);
        logic [1:48] o;
        for (int k = 1; k <= 48; k++) o[k] = d[PC2_TAB[k]];
        return o;
    endfunction

    // Decrypt round 1 reuses C16/D16 (== C0/D0) unrotated; later rounds mirror the encrypt amounts.
    function automatic logic [1:0] shift_amt(input logic [4:0] rnd, input logic dec);
        logic one_step;
        one_step = (rnd == 5'd1) || (rnd == 5'd2) || (rnd == 5'd9) || (rnd == 5'd16);
        if (dec && (rnd == 5'd1)) begin
            return 2'd0;
        end else if (one_step) begin
            return 2'd1;
        end else begin
            return 2'd2;
        end
    endfunction

    function automatic logic [1:28] rotl(input logic [1:28] h, input logic [1:0] n);
        logic [1:28] o;
        case (n)
            2'd1:    o = {h[2:28], h[1]};
            2'd2:    o = {h[3:28], h[1:2]};
            default: o = h;
        endcase
        return o;
    endfunction

`ifdef DES_DECRYPT_EN
    function automatic logic [1:28] rotr(input logic [1:28] h, input logic [1:0] n);
        logic [1:28] o;
        case (n)
            2'd1:    o = {h[28], h[1:27]};
            2'd2:    o = {h[27:28], h[1:26]};
            default: o = h;
        endcase
        return o;
    endfunction
`endif

    state_t      r_state;
    state_t      w_state_next;
    logic [1:32] r_l;
    logic [1:32] r_r;
    logic [1:28] r_c;
    logic [1:28] r_d;
    logic [4:0]  r_round;
    logic        r_valid;
    logic [1:64] r_data;
    logic [1:32] r_r_hold;
    logic [1:48] r_subkey_hold;
    logic        w_accept;
    logic        w_mode;
    logic [1:0]  w_amt;
    logic [1:28] w_c_next;
    logic [1:28] w_d_next;
    logic [1:48] w_subkey;
    logic [1:32] w_l_new;
    logic [1:32] w_r_new;

`ifdef DES_DECRYPT_EN
    logic        r_mode;
    assign w_mode = r_mode;
`else
    logic        w_unused_mode;
    assign w_unused_mode = mode_i;
    assign w_mode        = 1'b0;
`endif

    assign w_accept = valid_i && (r_state == S_IDLE);

    // Round datapath: next key halves, round subkey and Feistel half update
    always_comb begin
        w_amt = shift_amt(r_round, w_mode);
`ifdef DES_DECRYPT_EN
        if (w_mode) begin
            w_c_next = rotr(r_c, w_amt);
            w_d_next = rotr(r_d, w_amt);
        end else begin
            w_c_next = rotl(r_c, w_amt);
            w_d_next = rotl(r_d, w_amt);
        end
`else
        w_c_next = rotl(r_c, w_amt);
        w_d_next = rotl(r_d, w_amt);
`endif
        w_subkey = perm_pc2({w_c_next, w_d_next});
        w_l_new  = r_r;
        w_r_new  = r_l ^ f_i;
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_ROUND;
                else          w_state_next = S_IDLE;
            end
            S_ROUND: begin
                if (r_round == LAST_ROUND) w_state_next = S_DONE;
                else                       w_state_next = S_ROUND;
            end
            S_DONE: begin
                if (ready_i) w_state_next = S_IDLE;
                else         w_state_next = S_DONE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Block, key schedule, round counter and result registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_l           <= 32'd0;
            r_r           <= 32'd0;
            r_c           <= 28'd0;
            r_d           <= 28'd0;
            r_round       <= 5'd0;
            r_valid       <= 1'b0;
            r_data        <= 64'd0;
            r_r_hold      <= 32'd0;
            r_subkey_hold <= 48'd0;
`ifdef DES_DECRYPT_EN
            r_mode        <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        {r_l, r_r} <= perm_ip(data_i);
                        {r_c, r_d} <= perm_pc1(key_i);
                        r_round    <= 5'd1;
`ifdef DES_DECRYPT_EN
                        r_mode     <= mode_i;
`endif
                    end
                end
                S_ROUND: begin
                    r_l           <= w_l_new;
                    r_r           <= w_r_new;
                    r_c           <= w_c_next;
                    r_d           <= w_d_next;
                    r_r_hold      <= r_r;
                    r_subkey_hold <= w_subkey;
                    // FP input is R16||L16, which undoes the last half swap.
                    if (r_round == LAST_ROUND) begin
                        r_data  <= perm_fp({w_r_new, w_l_new});
                        r_valid <= 1'b1;
                        r_round <= 5'd0;
                    end else begin
                        r_round <= r_round + 5'd1;
                    end
                end
                S_DONE: begin
                    if (ready_i) r_valid <= 1'b0;
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    assign ready_o  = (r_state == S_IDLE);
    assign busy_o   = (r_state == S_ROUND) || (r_state == S_DONE);
    assign round_o  = r_round;
    assign valid_o  = r_valid;
    assign data_o   = r_data;
    assign r_o      = (r_state == S_ROUND) ? r_r : r_r_hold;
    assign subkey_o = (r_state == S_ROUND) ? w_subkey : r_subkey_hold;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Scoreboard bench for des_round_sequencer: full 16-round instance plus a single-round instance,
// both driven by a behavioural DES round function and key schedule model.
module tb_des_round_sequencer;
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
        59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
        10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
        7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
        16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53,
        46,42,50,36,29,32};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
        12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29,
        28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
        2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int S_T [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    typedef struct {
        logic [63:0] exp;
        logic [63:0] key;
        logic        dec;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, rdy_o0, m0, busy0, valid0, rdy_i0;
    logic [63:0] d0, k0, data0;
    logic [31:0] r0, f0;
    logic [47:0] sk0;
    logic [4:0]  round0;
    logic        v1, rdy_o1, m1, busy1, valid1, rdy_i1;
    logic [63:0] d1, k1, data1;
    logic [31:0] r1, f1;
    logic [47:0] sk1;
    logic [4:0]  round1;

    op_t q0[$];
    op_t q1[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  acc0 = 0, acc1 = 0, idx0 = 0;
    bit  pv0 = 1'b0, pv1 = 1'b0, post0 = 1'b0;

    function automatic logic [63:0] m_ip(input logic [63:0] x);
        logic [63:0] o;
        for (int k = 1; k <= 64; k++) o[64-k] = x[64-IP_T[k-1]];
        return o;
    endfunction

    // Inverse of IP: bit k of the input lands on position IP[k].
    function automatic logic [63:0] m_fp(input logic [63:0] x);
        logic [63:0] o;
        for (int k = 1; k <= 64; k++) o[64-IP_T[k-1]] = x[64-k];
        return o;
    endfunction

    function automatic logic [47:0] m_subkey(input logic [63:0] key, input int rnd);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] o;
        for (int k = 1; k <= 56; k++) cd[56-k] = key[64-PC1_T[k-1]];
        c = cd[55:28];
        d = cd[27:0];
        for (int j = 0; j < rnd; j++) begin
            for (int s = 0; s < SH_T[j]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
        end
        cd = {c, d};
        for (int k = 1; k <= 48; k++) o[48-k] = cd[56-PC2_T[k-1]];
        return o;
    endfunction

    function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s, o;
        logic [5:0]  six;
        int          row, col;
        for (int i = 1; i <= 48; i++) x[48-i] = r[32-E_T[i-1]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            row = {six[5], six[0]};
            col = six[4:1];
            s[31-4*b -: 4] = S_T[b*64 + row*16 + col][3:0];
        end
        for (int i = 1; i <= 32; i++) o[32-i] = s[32-P_T[i-1]];
        return o;
    endfunction

    function automatic logic [63:0] m_des(input logic [63:0] d, input logic [63:0] k,
                                          input int nr, input bit dec);
        logic [63:0] lr;
        logic [31:0] l, r, t;
        lr = m_ip(d);
        l  = lr[63:32];
        r  = lr[31:0];
        for (int i = 1; i <= nr; i++) begin
            t = r;
            r = l ^ m_f(r, m_subkey(k, dec ? 17 - i : i));
            l = t;
        end
        return m_fp({r, l});
    endfunction

    assign f0 = m_f(r0, sk0);
    assign f1 = m_f(r1, sk1);

    des_round_sequencer #(.NUM_ROUNDS(16)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .valid_i(v0), .ready_o(rdy_o0), .data_i(d0), .key_i(k0),
        .mode_i(m0), .r_o(r0), .subkey_o(sk0), .f_i(f0), .round_o(round0), .busy_o(busy0),
        .valid_o(valid0), .ready_i(rdy_i0), .data_o(data0)
    );

    des_round_sequencer #(.NUM_ROUNDS(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(v1), .ready_o(rdy_o1), .data_i(d1), .key_i(k1),
        .mode_i(m1), .r_o(r1), .subkey_o(sk1), .f_i(f1), .round_o(round1), .busy_o(busy1),
        .valid_o(valid1), .ready_i(rdy_i1), .data_o(data1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    // Monitor for the 16-round instance
    always @(negedge clk) begin
        if (!rst) begin
            if (post0) begin
                chk("after_hs_valid_o", 64'(valid0), 64'd0);
                chk("after_hs_ready_o", 64'(rdy_o0), 64'd1);
                post0 = 1'b0;
            end
            if (v0 && rdy_o0) acc0 = cyc + 1;
            if (round0 != 5'd0) begin
                if (q0.size() == 0) begin
                    timeout("round_without_op");
                end else begin
                    idx0 = q0[0].dec ? 17 - int'(round0) : int'(round0);
                    chk("subkey_o", 64'(sk0), 64'(m_subkey(q0[0].key, idx0)));
                end
            end
            if (valid0 && !pv0) chk("latency16", 64'(cyc - acc0), 64'd16);
            pv0 = valid0;
            if (valid0) begin
                if (q0.size() == 0) begin
                    timeout("valid_without_op");
                end else begin
                    chk("data_o", data0, q0[0].exp);
                    if (rdy_i0) begin
                        void'(q0.pop_front());
                        post0 = 1'b1;
                    end else begin
                        chk("bp_ready_o", 64'(rdy_o0), 64'd0);
                        chk("bp_busy_o", 64'(busy0), 64'd1);
                    end
                end
            end
        end else begin
            pv0   = 1'b0;
            post0 = 1'b0;
        end
    end

    // Monitor for the single-round instance
    always @(negedge clk) begin
        if (!rst) begin
            if (v1 && rdy_o1) acc1 = cyc + 1;
            if (round1 != 5'd0) chk("nr1_round_o", 64'(round1), 64'd1);
            if (valid1 && !pv1) chk("latency1", 64'(cyc - acc1), 64'd1);
            pv1 = valid1;
            if (valid1 && rdy_i1) begin
                if (q1.size() == 0) begin
                    timeout("nr1_valid_without_op");
                end else begin
                    chk("nr1_data_o", data1, q1[0].exp);
                    void'(q1.pop_front());
                end
            end
        end else begin
            pv1 = 1'b0;
        end
    end

    task automatic run_op(input int inst, input logic [63:0] d, input logic [63:0] k,
                          input logic md, input logic [63:0] exp, input bit wait_done);
        op_t op;
        int  n;
        op.exp = exp;
        op.key = k;
`ifdef DES_DECRYPT_EN
        op.dec = md;
`else
        op.dec = 1'b0;
`endif
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((inst == 0) ? rdy_o0 : rdy_o1) != 1'b1 && n < 50);
        if (n >= 50) timeout("wait_ready_o");
        @(posedge clk);
        #1;
        if (inst == 0) begin
            q0.push_back(op);
            v0 = 1'b1; d0 = d; k0 = k; m0 = md;
        end else begin
            q1.push_back(op);
            v1 = 1'b1; d1 = d; k1 = k; m1 = md;
        end
        @(posedge clk);
        #1;
        v0 = 1'b0;
        v1 = 1'b0;
        if (wait_done) begin
            n = 0;
            while (((inst == 0) ? q0.size() : q1.size()) != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) timeout("wait_result");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        v0 = 1'b0; d0 = 64'd0; k0 = 64'd0; m0 = 1'b0; rdy_i0 = 1'b1;
        v1 = 1'b0; d1 = 64'd0; k1 = 64'd0; m1 = 1'b0; rdy_i1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready_o", 64'(rdy_o0), 64'd1);
        chk("reset_valid_o", 64'(valid0), 64'd0);
        chk("reset_busy_o", 64'(busy0), 64'd0);
        chk("reset_round_o", 64'(round0), 64'd0);
        chk("reset_data_o", data0, 64'd0);
        chk("nr1_reset_ready_o", 64'(rdy_o1), 64'd1);

        run_op(0, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405, 1'b1);
        run_op(0, 64'h0, 64'h0, 1'b0, 64'h8CA64DE9C1B123A7, 1'b1);
`ifdef DES_DECRYPT_EN
        run_op(0, 64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1, 64'h0123456789ABCDEF, 1'b1);
`else
        run_op(0, 64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1,
               m_des(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 16, 1'b0), 1'b1);
`endif

        // Backpressure: result must hold while ready_i is low; stray valid_i pulses are ignored.
        rdy_i0 = 1'b0;
        run_op(0, 64'h0, 64'h0, 1'b0, 64'h8CA64DE9C1B123A7, 1'b0);
        n = 0;
        while (!valid0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) timeout("wait_valid_o");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            v0 = (i % 2 == 0);
            d0 = 64'hFFFF0000FFFF0000;
            k0 = 64'h0F0F0F0F0F0F0F0F;
        end
        @(posedge clk);
        #1;
        v0 = 1'b0;
        rdy_i0 = 1'b1;
        n = 0;
        while (q0.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeout("wait_bp_release");

        // Reset in the middle of round 7 aborts the operation.
        run_op(0, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405, 1'b0);
        n = 0;
        while (round0 != 5'd7 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) timeout("wait_round7");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(q0.pop_front());
        @(negedge clk);
        chk("abort_ready_o", 64'(rdy_o0), 64'd1);
        chk("abort_valid_o", 64'(valid0), 64'd0);
        chk("abort_round_o", 64'(round0), 64'd0);
        chk("abort_busy_o", 64'(busy0), 64'd0);
        run_op(0, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405, 1'b1);

        run_op(1, 64'h0, 64'h0, 1'b0, m_des(64'h0, 64'h0, 1, 1'b0), 1'b1);
        run_op(1, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0,
               m_des(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1, 1'b0), 1'b1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/des_round_sequencer.md
Name: des_round_sequencer

Overview:
Iterative DES engine controller. It accepts a 64-bit block and a 64-bit key over a valid/ready handshake. It applies IP and PC-1, then runs NUM_ROUNDS Feistel rounds at one round per cycle. It drives the external round function (E expansion, key XOR, S-boxes, P) with R and the round subkey, and returns FP(R‖L) over an output valid/ready handshake. All bit numbering is 1-indexed MSB-first per FIPS 46-3.

Parameters:
NUM_ROUNDS, 16, number of Feistel rounds executed (legal 1..16; reduced-round use for cryptanalysis experiments)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous, active-high reset
valid_i  input  1  input block/key valid
ready_o  output  1  sequencer can accept (high only in IDLE)
data_i  input  [1:64]  plaintext/ciphertext block
key_i  input  [1:64]  DES key, parity bits 8,16,…,64 ignored
mode_i  input  1  0 = encrypt, 1 = decrypt (see Optional Feature)
r_o  output  [1:32]  current R half, to round function
subkey_o  output  [1:48]  current round subkey, to round function
f_i  input  [1:32]  round function result f(r_o, subkey_o), combinational, same cycle
round_o  output  [4:0]  current round index 1..NUM_ROUNDS, 0 when not in ROUND
busy_o  output  1  high in ROUND or DONE
valid_o  output  1  result valid
ready_i  input  1  downstream accepts result
data_o  output  [1:64]  result block

Behaviour:
- Clock and reset: one clock, clk_i. Reset is rst_i, synchronous and active-high.
- Reset values: state=IDLE, ready_o=1, valid_o=0, busy_o=0, round_o=0, data_o=0, internal L/R/C/D=0.
- rst_i has priority over every event. Reset mid-ROUND or mid-DONE discards the operation; the next cycle is IDLE.
- States: IDLE, ROUND, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i&ready_o: L‖R ← IP(data_i), C‖D ← PC-1(key_i), latch mode, round counter ← 1, go to ROUND.
- ROUND (one cycle per round i):
  - Combinational: CDn = shift(C‖D, i, mode); subkey_o = PC-2(CDn); r_o = R.
  - At the clock edge: L ← R, R ← L ^ f_i, C‖D ← CDn.
  - If i == NUM_ROUNDS: data_o ← FP(R_new‖L_new), which applies the swap; valid_o ← 1; go to DONE. Otherwise i ← i+1.
- Encrypt shift: rotate each 28-bit half left by 1 in rounds 1, 2, 9, 16; by 2 in all other rounds.
- Decrypt shift:
  - Round 1: no rotation.
  - Rounds 2..16: rotate right by the encrypt amount of round 18−i. That is 1 for i ∈ {2, 9, 16}, else 2.
  - This yields K16…K1.
- Decrypt inverts encrypt only when NUM_ROUNDS=16. For reduced rounds it uses K16…K(17−N), which is documented as intended.
- DONE:
  - valid_o=1 and data_o held stable until ready_i.
  - On valid_o&ready_i: valid_o ← 0, go to IDLE.
  - A new input is not accepted in the same cycle; ready_o rises the following cycle.
- Outside ROUND: r_o and subkey_o hold their last values; the round function output is ignored.
- Latency: input accepted at edge t; rounds occupy cycles t+1..t+NUM_ROUNDS; valid_o is high from edge t+NUM_ROUNDS.
- Throughput: one block per NUM_ROUNDS+2 cycles at best.
- valid_i while not ready_o: ignored. Data and key are sampled only at the handshake.

Optional Feature:
Macro DES_DECRYPT_EN.
- Defined: mode_i is latched and the decrypt shift schedule is implemented.
- Undefined: mode_i is ignored and treated as 0. Only left rotations are synthesized. The port remains present.

Test Plan:
- Encrypt: key 0x133457799BBCDFF1, data 0x0123456789ABCDEF, f_i from the codebase round function, ready_i=1 → data_o=0x85E813540F0AB405, valid_o exactly 16 cycles after the accepting edge.
- Zero vector: key 0, data 0 → data_o=0x8CA64DE9C1B123A7. Subkey_o sequence matches the bench model K1..K16 per round_o.
- Decrypt (DES_DECRYPT_EN): key 0x133457799BBCDFF1, data 0x85E813540F0AB405, mode_i=1 → 0x0123456789ABCDEF. Without the macro, the same stimulus → encrypt result, with mode ignored.
- Backpressure: hold ready_i=0 for 5 cycles in DONE → data_o and valid_o stable, ready_o=0, valid_i pulses ignored. Release → valid_o drops, ready_o=1 the next cycle.
- Reset: assert rst_i at round 7 → the next cycle is IDLE, ready_o=1, valid_o=0, round_o=0. A fresh encrypt then produces the correct result.
- NUM_ROUNDS=1: key 0, data 0 → valid_o 1 cycle after accept, data_o equals the bench one-round model including the swap.
